// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

  localparam int unsigned W_DEFAULT = 8;

  localparam logic [W_DEFAULT-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StLdDvs = 3'b001,
    StIter  = 3'b010,
    StFix   = 3'b011,
    StDone  = 3'b100
  } state_e;

endpackage

// File: rtl/div_step.sv
// One non-restoring add/subtract-shift step; with fix set it is a plain R + D restore.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  input  logic         fix,
  output logic [W:0]   r_next,
  output logic [W-1:0] q_next
);

  logic [W:0] opa;
  logic [W:0] opb;
  logic       sub;

  always_comb begin
    opa    = fix ? r : {r[W-1:0], q[W-1]};
    opb    = {1'b0, d};
    // Subtract only while the partial remainder is non-negative and not restoring.
    sub    = !fix && !r[W];
    r_next = sub ? (opa - opb) : (opa + opb);
    q_next = {q[W-2:0], ~r_next[W]};
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned divider: dividend then divisor on the shared A bus, one step per clock.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   A,
  input  logic           go,
  output logic [2*W-1:0] Result,
  output logic           done,
  output logic           dbz,
  output logic [2:0]     state
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [W-1:0] DbzQuot = {W{DBZ_QUOTIENT[0]}};

  state_e         state_q, state_d;
  logic [W:0]     r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] result_q, result_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic           step_fix;
  logic [W:0]     step_r;
  logic [W-1:0]   step_q;
  logic [W:0]     r_fixed;

  assign step_fix = (state_q == StFix);

  div_step #(
    .W(W)
  ) u_step (
    .r     (r_q),
    .q     (q_q),
    .d     (d_q),
    .fix   (step_fix),
    .r_next(step_r),
    .q_next(step_q)
  );

  assign r_fixed = r_q[W] ? step_r : r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (go) state_d = StLdDvs;
      StLdDvs: state_d = (A == '0) ? StDone : StIter;
      StIter:  if (cnt_q == '0) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  if (go) state_d = StLdDvs;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    dbz_d    = dbz_q;
    case (state_q)
      StIdle, StDone: begin
        if (go) begin
          q_d    = A;
          r_d    = '0;
          done_d = 1'b0;
          dbz_d  = 1'b0;
        end
      end
      StLdDvs: begin
        d_d = A;
        if (A == '0) begin
          dbz_d    = 1'b1;
          done_d   = 1'b1;
          result_d = {q_q, DbzQuot};
        end else begin
          cnt_d = CW'(W - 1);
        end
      end
      StIter: begin
        r_d = step_r;
        q_d = step_q;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      StFix: begin
        r_d      = r_fixed;
        result_d = {r_fixed[W-1:0], q_q};
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Result = result_q;
  assign done   = done_q;
  assign dbz    = dbz_q;
  assign state  = state_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed-vector bench for nonrestoring_divider: table of divisions plus reset and back-to-back runs.
module tb_nonrestoring_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  A = '0;
  logic        go = 1'b0;
  logic [15:0] Result;
  logic        done;
  logic        dbz;
  logic [2:0]  state;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  nonrestoring_divider #(
    .W(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .go    (go),
    .Result(Result),
    .done  (done),
    .dbz   (dbz),
    .state (state)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns the edge index (go edge = 0) after which done was first seen; 0 on timeout.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    A  = a;
    go = 1'b1;
    @(negedge clk);
    go  = 1'b0;
    A   = b;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;

    vecs[0] = '{a: 8'd45,  b: 8'd7,   res: 16'h0306, dbz: 1'b0, lat: 10};
    vecs[1] = '{a: 8'd200, b: 8'd13,  res: 16'h050F, dbz: 1'b0, lat: 10};
    vecs[2] = '{a: 8'd255, b: 8'd1,   res: 16'h00FF, dbz: 1'b0, lat: 10};
    vecs[3] = '{a: 8'd5,   b: 8'd9,   res: 16'h0500, dbz: 1'b0, lat: 10};
    vecs[4] = '{a: 8'd255, b: 8'd255, res: 16'h0001, dbz: 1'b0, lat: 10};
    vecs[5] = '{a: 8'd77,  b: 8'd0,   res: 16'h4DFF, dbz: 1'b1, lat: 1};

    #3 rst = 1'b0;
    #1;
    check("reset_state", 32'(state), 32'h0);
    check("reset_result", 32'(Result), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_dbz", 32'(dbz), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i), 32'(Result), 32'(vecs[i].res));
      check($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
      check($sformatf("v%0d_state", i), 32'(state), 32'h4);
    end

    // Result must hold while idle in DONE.
    repeat (3) @(negedge clk);
    check("hold_result", 32'(Result), 32'h4DFF);
    check("hold_done", 32'(done), 32'h1);

    // Reset in the middle of iteration.
    @(negedge clk);
    A  = 8'd45;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    A  = 8'd7;
    repeat (5) @(negedge clk);
    check("mid_in_iter", 32'(state), 32'h2);
    rst = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'h0);
    check("mid_rst_result", 32'(Result), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_dbz", 32'(dbz), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_div(8'd45, 8'd7, lat);
    check("post_rst_latency", 32'(lat), 32'd10);
    check("post_rst_result", 32'(Result), 32'h0306);

    // Back-to-back: go asserted in the DONE cycle.
    A  = 8'd100;
    go = 1'b1;
    @(negedge clk);
    check("b2b_done_drop", 32'(done), 32'h0);
    check("b2b_state_lddvs", 32'(state), 32'h1);
    go  = 1'b0;
    A   = 8'd10;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    check("b2b_latency", 32'(lat), 32'd10);
    check("b2b_result", 32'(Result), 32'h000A);
    check("b2b_dbz", 32'(dbz), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
